// File: rtl/tmr_mismatch_monitor_pkg.sv
// tmr_mismatch_monitor_pkg: shared FSM encoding and parameter defaults for the TMR monitor
package tmr_mismatch_monitor_pkg;

    localparam int DEF_WIDTH  = 1;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_THRESH = 4;

    typedef enum logic [1:0] {
        stOk       = 2'd0,
        stMismatch = 2'd1,
        stAlarm    = 2'd2
    } tmrState_e;

endpackage

// File: rtl/tmr_mismatch_detect.sv
// tmr_mismatch_detect: combinational majority vote, disagreement flag and per-copy source flags
module tmr_mismatch_detect #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    output logic [WIDTH-1:0] maj,
    output logic             mis,
    output logic [2:0]       src
);

    assign maj = (inA & inB) | (inA & inC) | (inB & inC);
    assign mis = |((inA ^ inB) | (inA ^ inC));
    assign src = {|(inC ^ maj), |(inB ^ maj), |(inA ^ maj)};

endmodule

// File: rtl/tmr_mismatch_monitor.sv
// tmr_mismatch_monitor: votes a triplicated register, counts mismatch events and raises an alarm
module tmr_mismatch_monitor
    import tmr_mismatch_monitor_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int THRESH = DEF_THRESH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    output logic [WIDTH-1:0] voted,
    output logic             err,
    output logic [2:0]       errSrc,
    output logic [CNT_W-1:0] errCnt,
    output logic             alarm,
    input  logic             clrReq,
    output logic             clrAck
);

    logic [WIDTH-1:0] maj;
    logic             mis;
    logic [2:0]       src;
    logic             prevMis;
    logic             evt;
    logic             clrTake;
    logic [CNT_W-1:0] cntNext;
    logic [2:0]       srcNext;
    tmrState_e        stateQ;
    tmrState_e        stateD;

    tmr_mismatch_detect #(.WIDTH(WIDTH)) uDetect (
        .inA(inA),
        .inB(inB),
        .inC(inC),
        .maj(maj),
        .mis(mis),
        .src(src)
    );

    // a persistent mismatch is one event; a clear is ignored while its ack is still out
    assign evt     = mis & ~prevMis;
    assign clrTake = clrReq & ~clrAck;
    assign alarm   = (stateQ == stAlarm);

    // next count, source flags and state; a clear wins but keeps a coincident event
    always_comb begin
        cntNext = clrTake ? (evt ? CNT_W'(1) : '0) : ((evt && errCnt != '1) ? errCnt + 1'b1 : errCnt);
        srcNext = clrTake ? (evt ? src : 3'b000) : (errSrc | src);
        stateD  = clrTake ? (evt ? stMismatch : stOk) :
                  (stateQ == stAlarm || cntNext >= CNT_W'(THRESH)) ? stAlarm :
                  (stateQ == stOk) ? (evt ? stMismatch : stOk) :
                  (mis ? stMismatch : stOk);
    end

    // all registered outputs and state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voted   <= '0;
            err     <= 1'b0;
            errSrc  <= 3'b000;
            errCnt  <= '0;
            clrAck  <= 1'b0;
            stateQ  <= stOk;
            prevMis <= 1'b0;
        end else begin
            voted   <= maj;
            err     <= evt;
            errSrc  <= srcNext;
            errCnt  <= cntNext;
            clrAck  <= clrTake;
            stateQ  <= stateD;
            prevMis <= mis;
        end
    end

endmodule

// File: doc/tmr_mismatch_monitor.md
TMR_MISMATCH_MONITOR -- requirements
Module: tmr_mismatch_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bit width of each triplicated copy.
REQ-002 SHALL have parameter CNT_W, default 8: error counter width.
REQ-003 SHALL have parameter THRESH, default 4: error count that raises alarm; legal range 1..2^CNT_W-1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports inA, inB, inC  input  WIDTH  three copies of a triplicated register.
REQ-007 SHALL have port voted  output  WIDTH  registered bitwise 2-of-3 majority of inA/inB/inC.
REQ-008 SHALL have port err  output  1  registered; high for one cycle per new mismatch event.
REQ-009 SHALL have port errSrc  output  3  sticky flags; bit0/1/2 = copy A/B/C disagreed with majority.
REQ-010 SHALL have port errCnt  output  CNT_W  saturating count of mismatch events.
REQ-011 SHALL have port alarm  output  1  high while FSM is in ALARM.
REQ-012 SHALL have ports clrReq  input  1 and clrAck  output  1  clear handshake.

Function
REQ-013 SHALL define mismatch(t) = any bit where inA, inB, inC are not all equal at sample edge t.
REQ-014 SHALL define event = mismatch(t) AND NOT mismatch(t-1); a persistent mismatch counts once.
REQ-015 SHALL update voted one cycle after inputs are sampled (latency 1).
REQ-016 SHALL assert err exactly one cycle after the edge at which an event is sampled.
REQ-017 SHALL OR into errSrc, on each mismatch cycle, the copies differing from majority on any bit.
REQ-018 SHALL increment errCnt by 1 per event and saturate at 2^CNT_W-1, never wrapping.
REQ-019 SHALL implement FSM states OK, MISMATCH, ALARM.
REQ-020 SHALL transition OK->MISMATCH on event; MISMATCH->OK when mismatch clears and errCnt < THRESH.
REQ-021 SHALL enter ALARM from OK or MISMATCH on the cycle errCnt becomes >= THRESH.
REQ-022 SHALL leave ALARM only through a clear, returning to OK.
REQ-023 SHALL, on clrReq sampled high, pulse clrAck for exactly one cycle on the next cycle.
REQ-024 SHALL, in that same update, zero errCnt and errSrc and go to OK.
REQ-025 SHALL ignore clrReq while clrAck is high; a held clrReq produces one ack every two cycles.
REQ-026 SHALL let clear win over a simultaneous event: errCnt becomes 1, errSrc gets that event's flags, state MISMATCH.
REQ-027 SHALL keep updating voted while in ALARM; counting continues up to saturation.

Reset
REQ-028 SHALL, on rst high and independent of clk, drive voted=0, err=0, errSrc=0, errCnt=0, alarm=0, clrAck=0, state=OK, previous-mismatch flag=0.
REQ-029 SHALL treat the first edge after rst release as having no previous mismatch, so a mismatch there is an event.
REQ-030 SHALL abort any pending clear handshake on reset; no clrAck is issued for a clrReq sampled before reset.

Structure
REQ-031 SHALL place FSM state encoding and parameter defaults in a shared package used by this block and its bench.
REQ-032 SHALL use one combinational sub-module, tmr_mismatch_detect, producing the majority word, mismatch flag and 3-bit source flags.
REQ-033 SHALL itself be single-clock, non-triplicated logic.

Verification
REQ-034 SHALL test: WIDTH=1, inA=inB=inC=1 for 10 cycles -> voted=1 from cycle 2, err never high, errCnt=0.
REQ-035 SHALL test: inB flipped for 3 consecutive cycles -> one err pulse, errCnt=1, errSrc=3'b010, state back to OK after the mismatch clears.
REQ-036 SHALL test: four separated single-cycle faults on inC -> errCnt=4, alarm rises the cycle the count hits 4, and alarm stays high after inputs agree.
REQ-037 SHALL test: clrReq pulsed in ALARM -> clrAck one cycle later, errCnt=0, errSrc=0, alarm=0.
REQ-038 SHALL test: CNT_W=2, THRESH=3 with six events -> errCnt saturates at 3, no wrap.
REQ-039 SHALL test: clrReq coincident with a new inA fault -> errCnt=1, errSrc=3'b001, state MISMATCH; rst asserted mid-count -> all outputs zero immediately.
